conv2d_seq_engine: RTL
======================

Name: conv2d_seq_engine

Overview:
- Sequential multi-channel 2-D convolution engine; successor to the flat combinational conv stage in Core/SA_rtl/Conv2d.
- Computes one (out-channel, out-pixel) window dot product per in-channel per cycle using WEIGHT_WIDTH*WEIGHT_HEIGHT parallel multipliers.
- Accumulates across in-channels, adds per-out-channel bias, saturates, applies a selectable activation, and returns the whole feature map over a valid/ready handshake.

Parameters:
- BITWIDTH, 8: signed width of image and weight elements.
- IMAGE_WIDTH, 4: input width in pixels.
- IMAGE_HEIGHT, 4: input height in pixels.
- WEIGHT_WIDTH, 3: kernel width.
- WEIGHT_HEIGHT, 3: kernel height.
- IN_CHANNEL, 2: input channel count, >=1.
- OUT_CHANNEL, 2: output channel count, >=1.
- STRIDE, 1: stride in both axes, >=1.
- PADDING, 0: zero-padding on every edge.
- USING_BIAS, 1: 0 forces bias to zero.
- ACT_MODE, 0: 0 = none, 1 = ReLU, 2 = clipped ReLU.
- ACT_MAX_VAL, 6: clip ceiling for ACT_MODE 2.
- Derived:
  - OUT_W = 2*BITWIDTH.
  - OUT_IMAGE_WIDTH = (IMAGE_WIDTH-WEIGHT_WIDTH+2*PADDING)/STRIDE+1; OUT_IMAGE_HEIGHT likewise.
  - ACC_W = 2*BITWIDTH + clog2(IN_CHANNEL*WEIGHT_WIDTH*WEIGHT_HEIGHT) + 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- valid, input, 1: new job offered.
- ready, output, 1: engine idle and able to accept a job.
- image, input, IN_CHANNEL*IMAGE_WIDTH*IMAGE_HEIGHT*BITWIDTH: signed pixels, MSB-first, channel-major then row-major.
- weights_mem, input, IN_CHANNEL*OUT_CHANNEL*WEIGHT_WIDTH*WEIGHT_HEIGHT*BITWIDTH: MSB-first, ordered [ic][oc][ky][kx].
- bias_mem, input, OUT_CHANNEL*OUT_W: MSB-first per out-channel.
- out_valid, output, 1: result complete.
- out_ready, input, 1: consumer accepts result.
- result, output, OUT_CHANNEL*OUT_IMAGE_WIDTH*OUT_IMAGE_HEIGHT*OUT_W: MSB-first, ordered [oc][oy][ox].

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On the rst edge: state IDLE, all counters 0, accumulator 0, result 0, out_valid 0. ready=0 while rst is high, 1 in the first cycle after rst deasserts. Reset mid-CALC or mid-DONE aborts the job; no partial result is retained.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - On valid&&ready at an edge, latch image, weights_mem and bias_mem into internal registers, zero all counters and the accumulator, go to CALC.
  - Input buses may change freely after acceptance.
- CALC:
  - ready=0, out_valid=0.
  - Counter nest, outermost to innermost: oc, oy, ox, ic. ic advances every cycle.
  - Each cycle: partial = sum over ky,kx of pixel(ic, oy*STRIDE+ky-PADDING, ox*STRIDE+kx-PADDING) * w(ic,oc,ky,kx). Products are full signed 2*BITWIDTH wide; out-of-range pixel coordinates read as 0.
  - If ic<IN_CHANNEL-1: acc <= acc + partial.
  - If ic==IN_CHANNEL-1:
    - s = acc + partial + bias[oc], computed in ACC_W sign-extended.
    - Saturate s to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - Apply activation: mode 1 gives max(x,0); mode 2 gives min(max(x,0), ACT_MAX_VAL).
    - Write the value into result slot (oc,oy,ox) and clear acc.
  - Total CALC length N = OUT_CHANNEL*OUT_IMAGE_HEIGHT*OUT_IMAGE_WIDTH*IN_CHANNEL cycles. On the edge completing the last slot, go to DONE.
- DONE:
  - out_valid=1, ready=0; result is stable.
  - On out_valid&&out_ready, go to IDLE.
- Latency: acceptance at edge t0; out_valid rises after edge t0+N. With defaults N=16.
- result holds its last completed value in IDLE until the next job's first slot write. Slots not yet rewritten keep their old values during CALC.
- valid is ignored outside IDLE. Back-to-back jobs are allowed: the cycle after the DONE handshake, ready=1.
- No simultaneous-event ambiguity: input and output handshakes are never both possible in the same state.

Test Plan:
- Defaults, image all 1, weights all 1, USING_BIAS=0, ACT_MODE=0 -> all 8 outputs = 18. out_valid high exactly 16 edges after acceptance; ready low throughout.
- Same data, bias oc0=-20, oc1=5, ACT_MODE=1 -> oc0 outputs 0 (-2 clamped), oc1 outputs 23. Same data with ACT_MODE=2 and ACT_MAX_VAL=6, bias 0 -> all outputs 6.
- Image all -128, weights all -128 -> all outputs 32767 (saturated from 294912). Weights all 127 -> all outputs -32768 (from -292608), ACT_MODE=0.
- PADDING=1, all-ones data, bias 0 -> 4x4 map per oc: corners 8, edges 12, interior 18. N=64 cycles.
- out_ready held low 10 cycles in DONE -> out_valid and result constant, ready=0; a valid pulse mid-CALC is ignored. After out_ready=1, ready=1 on the next cycle and a second job with different data completes correctly.
- rst asserted 1 cycle at CALC cycle 5 -> next edge out_valid=0 and result=0; ready=1 after release; a fresh job gives the first test's values.

Source files
------------

// File: rtl/conv2d_seq_engine.sv
// conv2d_seq_engine
// Sequential multi-channel 2-D convolution. One in-channel of one
// (out-channel, out-pixel) window is reduced per cycle with
// WEIGHT_WIDTH*WEIGHT_HEIGHT multipliers. Partial sums accumulate across
// in-channels. The total gets bias, signed saturation to OUT_W and an optional
// activation. It is then written into the result map.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   valid / ready : job handshake; operands are captured on acceptance
//   image         : [ic][y][x] signed pixels, MSB-first
//   weights_mem   : [ic][oc][ky][kx] signed weights, MSB-first
//   bias_mem      : [oc] signed OUT_W-bit bias, MSB-first
//   out_valid / out_ready : result handshake
//   result        : [oc][oy][ox] signed OUT_W-bit outputs, MSB-first
module conv2d_seq_engine #(
  parameter int BITWIDTH      = 8,
  parameter int IMAGE_WIDTH   = 4,
  parameter int IMAGE_HEIGHT  = 4,
  parameter int WEIGHT_WIDTH  = 3,
  parameter int WEIGHT_HEIGHT = 3,
  parameter int IN_CHANNEL    = 2,
  parameter int OUT_CHANNEL   = 2,
  parameter int STRIDE        = 1,
  parameter int PADDING       = 0,
  parameter int USING_BIAS    = 1,
  parameter int ACT_MODE      = 0,
  parameter int ACT_MAX_VAL   = 6,
  localparam int OUT_W            = 2 * BITWIDTH,
  localparam int OUT_IMAGE_WIDTH  = (IMAGE_WIDTH - WEIGHT_WIDTH + 2 * PADDING) / STRIDE + 1,
  localparam int OUT_IMAGE_HEIGHT = (IMAGE_HEIGHT - WEIGHT_HEIGHT + 2 * PADDING) / STRIDE + 1,
  localparam int ACC_W = 2 * BITWIDTH + $clog2(IN_CHANNEL * WEIGHT_WIDTH * WEIGHT_HEIGHT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic ready,
  input  logic [IN_CHANNEL*IMAGE_WIDTH*IMAGE_HEIGHT*BITWIDTH-1:0]                image,
  input  logic [IN_CHANNEL*OUT_CHANNEL*WEIGHT_WIDTH*WEIGHT_HEIGHT*BITWIDTH-1:0] weights_mem,
  input  logic [OUT_CHANNEL*OUT_W-1:0]                                           bias_mem,
  output logic out_valid,
  input  logic out_ready,
  output logic [OUT_CHANNEL*OUT_IMAGE_WIDTH*OUT_IMAGE_HEIGHT*OUT_W-1:0]          result
);

  localparam int IMG_BITS = IN_CHANNEL * IMAGE_WIDTH * IMAGE_HEIGHT * BITWIDTH;
  localparam int WGT_BITS = IN_CHANNEL * OUT_CHANNEL * WEIGHT_WIDTH * WEIGHT_HEIGHT * BITWIDTH;
  localparam int BIAS_BITS = OUT_CHANNEL * OUT_W;
  localparam int RES_BITS = OUT_CHANNEL * OUT_IMAGE_WIDTH * OUT_IMAGE_HEIGHT * OUT_W;
  localparam int IC_W = (IN_CHANNEL > 1) ? $clog2(IN_CHANNEL) : 1;
  localparam int OC_W = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1;
  localparam int OX_W = (OUT_IMAGE_WIDTH > 1) ? $clog2(OUT_IMAGE_WIDTH) : 1;
  localparam int OY_W = (OUT_IMAGE_HEIGHT > 1) ? $clog2(OUT_IMAGE_HEIGHT) : 1;
  localparam int IX_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int IY_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] ACT_MAX = OUT_W'(ACT_MAX_VAL);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  state_e state_q, state_d;

  logic signed [BITWIDTH-1:0] img_q  [IN_CHANNEL][IMAGE_HEIGHT][IMAGE_WIDTH];
  logic signed [BITWIDTH-1:0] wgt_q  [IN_CHANNEL][OUT_CHANNEL][WEIGHT_HEIGHT][WEIGHT_WIDTH];
  logic signed [OUT_W-1:0]    bias_q [OUT_CHANNEL];
  logic signed [OUT_W-1:0]    res_q  [OUT_CHANNEL][OUT_IMAGE_HEIGHT][OUT_IMAGE_WIDTH];

  logic [IC_W-1:0] ic_q;
  logic [OC_W-1:0] oc_q;
  logic [OX_W-1:0] ox_q;
  logic [OY_W-1:0] oy_q;
  logic signed [ACC_W-1:0] acc_q;

  logic accept, last_ic, last_ox, last_oy, last_oc, last_slot;
  int py, px;
  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [ACC_W-1:0] partial, sum_ic, bias_ext, sum_full;
  logic signed [OUT_W-1:0] sat, act_val;

  assign accept    = valid && ready;
  assign last_ic   = (ic_q == IC_W'(IN_CHANNEL - 1));
  assign last_ox   = (ox_q == OX_W'(OUT_IMAGE_WIDTH - 1));
  assign last_oy   = (oy_q == OY_W'(OUT_IMAGE_HEIGHT - 1));
  assign last_oc   = (oc_q == OC_W'(OUT_CHANNEL - 1));
  assign last_slot = last_ic && last_ox && last_oy && last_oc;

  // ---------------- FSM: state register ----------------
  // NOTE: every clocked process uses non-blocking (<=) so all registers
  // update from the same pre-edge values; blocking here would create races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)    state_d = S_CALC;
      S_CALC: if (last_slot) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready     = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
  end

  // NOTE: the operand copies carry no reset; they are only read during CALC,
  // which can only be entered through an acceptance that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < IN_CHANNEL; c++)
        for (int y = 0; y < IMAGE_HEIGHT; y++)
          for (int x = 0; x < IMAGE_WIDTH; x++)
            img_q[c][y][x] <= image[IMG_BITS-1-((c*IMAGE_HEIGHT+y)*IMAGE_WIDTH+x)*BITWIDTH -: BITWIDTH];
      for (int c = 0; c < IN_CHANNEL; c++)
        for (int o = 0; o < OUT_CHANNEL; o++)
          for (int ky = 0; ky < WEIGHT_HEIGHT; ky++)
            for (int kx = 0; kx < WEIGHT_WIDTH; kx++)
              wgt_q[c][o][ky][kx] <= weights_mem[WGT_BITS-1-(((c*OUT_CHANNEL+o)*WEIGHT_HEIGHT+ky)*WEIGHT_WIDTH+kx)*BITWIDTH -: BITWIDTH];
      for (int o = 0; o < OUT_CHANNEL; o++)
        bias_q[o] <= bias_mem[BIAS_BITS-1-o*OUT_W -: OUT_W];
    end
  end

  // One window of one in-channel; coordinates outside the image are padding
  // and contribute nothing.
  always_comb begin
    partial = '0;
    py      = 0;
    px      = 0;
    prod    = '0;
    for (int ky = 0; ky < WEIGHT_HEIGHT; ky++) begin
      for (int kx = 0; kx < WEIGHT_WIDTH; kx++) begin
        py = int'(oy_q) * STRIDE + ky - PADDING;
        px = int'(ox_q) * STRIDE + kx - PADDING;
        if (py >= 0 && py < IMAGE_HEIGHT && px >= 0 && px < IMAGE_WIDTH) begin
          prod    = img_q[ic_q][IY_W'(py)][IX_W'(px)] * wgt_q[ic_q][oc_q][ky][kx];
          partial = partial + ACC_W'(prod);
        end
      end
    end
  end

  // Finalisation: bias, saturate to OUT_W, then activation.
  always_comb begin
    sum_ic   = acc_q + partial;
    bias_ext = (USING_BIAS != 0) ? ACC_W'(bias_q[oc_q]) : '0;
    sum_full = sum_ic + bias_ext;
    if (sum_full > SAT_MAX)      sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sum_full < SAT_MIN) sat = {1'b1, {(OUT_W-1){1'b0}}};
    else                         sat = sum_full[OUT_W-1:0];
    act_val = sat;
    if (ACT_MODE != 0 && act_val < 0)       act_val = '0;
    if (ACT_MODE == 2 && act_val > ACT_MAX) act_val = ACT_MAX;
  end

  // Counters, accumulator and result map.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_q  <= '0;
      ox_q  <= '0;
      oy_q  <= '0;
      oc_q  <= '0;
      acc_q <= '0;
      for (int o = 0; o < OUT_CHANNEL; o++)
        for (int y = 0; y < OUT_IMAGE_HEIGHT; y++)
          for (int x = 0; x < OUT_IMAGE_WIDTH; x++)
            res_q[o][y][x] <= '0;
    end else if (accept) begin
      ic_q  <= '0;
      ox_q  <= '0;
      oy_q  <= '0;
      oc_q  <= '0;
      acc_q <= '0;
    end else if (state_q == S_CALC) begin
      if (last_ic) begin
        res_q[oc_q][oy_q][ox_q] <= act_val;
        acc_q                   <= '0;
      end else begin
        acc_q <= sum_ic;
      end
      // Nest oc > oy > ox > ic; ic steps every cycle.
      ic_q <= last_ic ? '0 : ic_q + IC_W'(1);
      if (last_ic)
        ox_q <= last_ox ? '0 : ox_q + OX_W'(1);
      if (last_ic && last_ox)
        oy_q <= last_oy ? '0 : oy_q + OY_W'(1);
      if (last_ic && last_ox && last_oy)
        oc_q <= last_oc ? '0 : oc_q + OC_W'(1);
    end
  end

  always_comb begin
    result = '0;
    for (int o = 0; o < OUT_CHANNEL; o++)
      for (int y = 0; y < OUT_IMAGE_HEIGHT; y++)
        for (int x = 0; x < OUT_IMAGE_WIDTH; x++)
          result[RES_BITS-1-((o*OUT_IMAGE_HEIGHT+y)*OUT_IMAGE_WIDTH+x)*OUT_W -: OUT_W] = res_q[o][y][x];
  end

endmodule
